// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-port fair arbiter in front of an SDRAM controller with in-order read return routing
module sdram_arbiter #(
    parameter int AW       = 24,
    parameter int DW       = 16,
    parameter int RD_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req,
    input  logic          p0_write,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ready,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_write,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ready,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          sdram_req,
    output logic          sdram_write,
    output logic [AW-1:0] sdram_addr,
    output logic [DW-1:0] sdram_wdata,
    input  logic          sdram_ready,
    input  logic          sdram_rvalid,
    input  logic [DW-1:0] sdram_rdata,
    output logic          err_orphan
);

    localparam int PW = $clog2(RD_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(RD_DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nxt;
    logic          owner, owner_nxt;
    logic          last, last_nxt;
    logic          grant_id;
    logic          grant_req;
    logic          g_write;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    logic          out_en;
    logic          accept;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          head;

    logic [RD_DEPTH-1:0] tag_mem;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [PW:0]         count;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = tag_mem[rd_ptr];

    always_comb begin
        grant_id  = owner;
        grant_req = 1'b0;
        case (state)
            IDLE: begin
                grant_req = p0_req | p1_req;
                if (p0_req && p1_req) grant_id = ~last;
                else                  grant_id = p1_req;
            end
            BUSY: begin
                grant_id  = owner;
                grant_req = owner ? p1_req : p0_req;
            end
            default: begin
                grant_id  = owner;
                grant_req = 1'b0;
            end
        endcase
    end

    assign g_write = grant_id ? p1_write : p0_write;
    assign g_addr  = grant_id ? p1_addr  : p0_addr;
    assign g_wdata = grant_id ? p1_wdata : p0_wdata;

    // Outputs are gated by rst_n so they drop the moment reset asserts.
    assign out_en      = rst_n & grant_req;
    assign sdram_req   = out_en & ~(~g_write & full);
    assign sdram_write = out_en & g_write;
    assign sdram_addr  = out_en ? g_addr  : '0;
    assign sdram_wdata = out_en ? g_wdata : '0;

    assign accept   = sdram_req & sdram_ready;
    assign p0_ready = accept & ~grant_id;
    assign p1_ready = accept &  grant_id;

    assign push      = accept & ~g_write;
    assign pop       = sdram_rvalid & ~empty;
    assign p0_rvalid = pop & ~head;
    assign p1_rvalid = pop &  head;
    assign p0_rdata  = sdram_rdata;
    assign p1_rdata  = sdram_rdata;

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (grant_req) begin
                    if (accept) begin
                        last_nxt = grant_id;
                    end else begin
                        state_nxt = BUSY;
                        owner_nxt = grant_id;
                    end
                end
            end
            BUSY: begin
                if (accept) begin
                    state_nxt = IDLE;
                    last_nxt  = owner;
                end else if (!grant_req) begin
                    // Owner withdrew its request; release the lock rather than stall.
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_mem    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= grant_id;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if (sdram_rvalid && empty) err_orphan <= 1'b1;
        end
    end

endmodule
